reduce_sum_stream: RTL and testbench



---
 rtl/reduce_sum_stream_pkg.sv | 16 +
 rtl/reduce_sum_stream_acc_add.sv | 31 +++
 rtl/reduce_sum_stream.sv | 100 ++++++++++
 tb/tb_reduce_sum_stream.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_sum_stream_pkg.sv
// Shared defaults and helpers for the streaming SUM-reduction stage.
// Optional build macro used by this slice: REDUCE_SATURATE_EN (clamping accumulator).
package reduce_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 8;

    localparam logic [ACC_W_DEF-1:0] ACC_MAX = '1;

    // Zero-extending an element into the accumulator needs at least as many bits.
    function automatic bit ext_width_ok(input int data_w, input int acc_w);
        return acc_w >= data_w;
    endfunction

endpackage

// File: rtl/reduce_sum_stream_acc_add.sv
// Combinational accumulator adder with carry-out; with REDUCE_SATURATE_EN defined
// the sum clamps to all ones on a carry instead of wrapping.
module acc_add #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] elem_ext,
    output logic [ACC_W-1:0] sum,
    output logic             carry_out
);

    logic [ACC_W:0] raw;

`ifdef REDUCE_SATURATE_EN
    function automatic logic [ACC_W-1:0] sat_clamp(input logic [ACC_W:0] wide);
        return wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    endfunction
`endif

    always_comb begin
        raw       = {1'b0, acc} + {1'b0, elem_ext};
        carry_out = raw[ACC_W];
`ifdef REDUCE_SATURATE_EN
        // Once clamped, acc stays all ones: any further nonzero add carries again.
        sum       = sat_clamp(raw);
`else
        sum       = raw[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/reduce_sum_stream.sv
// Streaming SUM reduction: accumulates a valid/ready packet and emits sum, count and overflow.
// Build option REDUCE_SATURATE_EN selects a clamping accumulator (see acc_add).
module reduce_sum_stream
    import reduce_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              out_valid,
    input  logic              out_ready
);

    if (!ext_width_ok(DATA_W, ACC_W)) begin : g_width_chk
        $error("reduce_sum_stream: ACC_W must be >= DATA_W");
    end

    logic [ACC_W-1:0] acc_p0;
    logic [CNT_W-1:0] cnt_p0;
    logic             ovf_p0;

    logic [ACC_W-1:0] sum_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             ovf_p1;
    logic             vld_p1;

    logic [ACC_W-1:0] elem_ext;
    logic [ACC_W-1:0] sum_nxt;
    logic             carry;
    logic             accept;
    logic             consume;

    assign elem_ext = ACC_W'(in_data);

    acc_add #(.ACC_W(ACC_W)) u_acc_add (
        .acc       (acc_p0),
        .elem_ext  (elem_ext),
        .sum       (sum_nxt),
        .carry_out (carry)
    );

    // Single result register: a consume this cycle frees it for a new result.
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = vld_p1 && out_ready;

    // Stage p0: running accumulation over the current packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
            ovf_p0 <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                acc_p0 <= '0;
                cnt_p0 <= '0;
                ovf_p0 <= 1'b0;
            end else begin
                acc_p0 <= sum_nxt;
                cnt_p0 <= cnt_p0 + CNT_W'(1);
                ovf_p0 <= ovf_p0 | carry;
            end
        end
    end

    // Stage p1: per-packet result held until downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1 <= '0;
            cnt_p1 <= '0;
            ovf_p1 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            if (consume) begin
                vld_p1 <= 1'b0;
            end
            if (accept && in_last) begin
                sum_p1 <= sum_nxt;
                cnt_p1 <= cnt_p0 + CNT_W'(1);
                ovf_p1 <= ovf_p0 | carry;
                vld_p1 <= 1'b1;
            end
        end
    end

    assign out_sum      = sum_p1;
    assign out_count    = cnt_p1;
    assign out_overflow = ovf_p1;
    assign out_valid    = vld_p1;

endmodule

// File: tb/tb_reduce_sum_stream.sv
// Scoreboard bench for reduce_sum_stream: directed packets plus randomized traffic.
module tb_reduce_sum_stream;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;
    logic              out_valid;
    logic              out_ready;

    reduce_sum_stream #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_sum      (out_sum),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int cnt;
        int ovf;
    } exp_t;

    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    rdy_mode = 0;      // 0: always ready, 1: random, 2: stalled
    longint m_tot = 0;
    int    m_cnt = 0;
    int    cyc = 0;
    int    pop_cyc = 0;
    int    prev_pop_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_accept(input int d, input bit last);
        exp_t e;
        m_tot += d;
        m_cnt++;
        if (last) begin
            e.ovf = (m_tot > longint'((1 << ACC_W) - 1)) ? 1 : 0;
`ifdef REDUCE_SATURATE_EN
            e.sum = e.ovf ? (1 << ACC_W) - 1 : int'(m_tot);
`else
            e.sum = int'(m_tot % (longint'(1) << ACC_W));
`endif
            e.cnt = m_cnt % (1 << CNT_W);
            exp_q.push_back(e);
            m_tot = 0;
            m_cnt = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic send_beat(input int d, input bit last);
        int w = 0;
        in_valid = 1'b1;
        in_data  = d[DATA_W-1:0];
        in_last  = last;
        @(negedge clk);
        while (!in_ready && w < 1000) begin
            tick();
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        else model_accept(d, last);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Output side: every visible result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 32'(out_valid), 32'd0);
                end else begin
                    chk("out_sum", 32'(out_sum), exp_q[0].sum);
                    chk("out_count", 32'(out_count), exp_q[0].cnt);
                    chk("out_overflow", 32'(out_overflow), exp_q[0].ovf);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        prev_pop_cyc = pop_cyc;
                        pop_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d results pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int w;
        rst_n = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_overflow", 32'(out_overflow), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Packet 1,2,3,4
        rdy_mode = 0;
        for (int i = 1; i <= 4; i++) send_beat(i, i == 4);
        repeat (3) tick();

        // Single-beat packets back to back
        send_beat(255, 1'b1);
        send_beat(7, 1'b1);
        repeat (2) tick();
        chk("b2b_gap", 32'(pop_cyc - prev_pop_cyc), 32'd1);

        // Long all-ones packet: wraps both sum and count
        for (int i = 0; i < 258; i++) send_beat(255, i == 257);
        repeat (3) tick();

        // Hold result with downstream stalled
        rdy_mode = 2;
        send_beat(3, 1'b0);
        send_beat(4, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'd6;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        rdy_mode = 0;
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        send_beat(6, 1'b1);
        repeat (3) tick();

        // Reset mid-packet
        send_beat(9, 1'b0);
        send_beat(9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        m_tot = 0;
        m_cnt = 0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sum", 32'(out_sum), 32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        chk("midrst_out_overflow", 32'(out_overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_beat(5, 1'b1);
        repeat (3) tick();

        // Randomized traffic
        rdy_mode = 1;
        for (int p = 0; p < 1000; p++) begin
            len = ($urandom_range(0, 49) == 0) ? int'($urandom_range(250, 300))
                                               : int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) tick();
                end
                send_beat(($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)),
                          b == len - 1);
            end
        end

        rdy_mode = 0;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        repeat (2) tick();
        chk("drain_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
